// File: rtl/min_max_ctrl_pkg.sv
// min_max_pkg: shared types for the min/max display control stage.
package min_max_pkg;
  typedef enum logic [1:0] {
    COM_NORMAL  = 2'b00,
    COM_LINEAR  = 2'b01,
    COM_ALL_OFF = 2'b10,
    COM_ALL_ON  = 2'b11
  } com_t;
  function automatic int reset_max(int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/min_max_ctrl_if.sv
// min_max_ctrl_if: button/switch inputs and display-side outputs of min_max_ctrl.
interface min_max_ctrl_if import min_max_pkg::*; #(parameter int VALSIZE = 4) ();
  com_t               com_i;
  logic [VALSIZE-1:0] min_sw_i;
  logic [VALSIZE-1:0] max_sw_i;
  logic               load_i;
  logic               inc_i;
  logic               dec_i;
  com_t               com_o;
  logic [VALSIZE-1:0] min_o;
  logic [VALSIZE-1:0] max_o;
  logic [VALSIZE-1:0] val_o;
  logic               osc_o;
  modport master (
    output com_i, min_sw_i, max_sw_i, load_i, inc_i, dec_i,
    input  com_o, min_o, max_o, val_o, osc_o
  );
  modport slave (
    input  com_i, min_sw_i, max_sw_i, load_i, inc_i, dec_i,
    output com_o, min_o, max_o, val_o, osc_o
  );
endinterface

// File: rtl/min_max_ctrl_btn.sv
// min_max_btn: one-cycle step pulse on a button's rising edge; with
// MIN_MAX_CTRL_REPEAT_EN defined, holding the button also auto-repeats.
module min_max_btn #(
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic step_o
);
  logic btn_q;
  logic rise;
  assign rise = btn_i & ~btn_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) btn_q <= 1'b0;
    else btn_q <= btn_i;
`ifdef MIN_MAX_CTRL_REPEAT_EN
  localparam int CW = $clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT} st_t;
  st_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      st_q  <= S_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  // The count restarts on every issued step, so WAIT and REPEAT share one counter.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q + 1'b1;
    step_o = 1'b0;
    if (!btn_i) begin
      st_d  = S_IDLE;
      cnt_d = '0;
    end else if (st_q == S_IDLE) begin
      cnt_d  = '0;
      st_d   = rise ? S_WAIT : S_IDLE;
      step_o = rise;
    end else if (cnt_q == CW'(st_q == S_WAIT ? REPEAT_DELAY - 1 : REPEAT_RATE - 1)) begin
      st_d   = S_REPEAT;
      cnt_d  = '0;
      step_o = 1'b1;
    end
  end
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_DELAY, REPEAT_RATE};
  assign step_o = rise;
`endif
endmodule

// File: rtl/min_max_ctrl.sv
// min_max_ctrl: buttons/switches to display-block inputs with a saturating value
// and blink divider; define MIN_MAX_CTRL_REPEAT_EN for hold-to-repeat on inc/dec.
module min_max_ctrl import min_max_pkg::*; #(
  parameter int VALSIZE      = 4,
  parameter int OSC_HALF     = 25000000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000
) (
  input logic           clk_i,
  input logic           rst_i,
  min_max_ctrl_if.slave bus
);
  typedef logic [VALSIZE-1:0] val_t;
  localparam val_t RST_MAX = val_t'(reset_max(VALSIZE));
  localparam int DW = OSC_HALF > 1 ? $clog2(OSC_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(OSC_HALF - 1);
  com_t          com_q, com_d;
  val_t          min_q, min_d, max_q, max_d, val_q, val_d, lo, hi;
  logic [DW-1:0] div_q, div_d;
  logic          osc_q, osc_d, load_q, load_edge, normal, inc_step, dec_step;
  min_max_btn #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_inc (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(bus.inc_i), .step_o(inc_step)
  );
  min_max_btn #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dec (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(bus.dec_i), .step_o(dec_step)
  );
  // Clamping and stepping use the requested mode and the bounds before any load this cycle.
  always_comb begin
    com_d     = bus.com_i;
    normal    = bus.com_i == COM_NORMAL;
    lo        = normal ? min_q : '0;
    hi        = normal ? max_q : '1;
    load_edge = bus.load_i & ~load_q;
    min_d     = load_edge ? (bus.min_sw_i < bus.max_sw_i ? bus.min_sw_i : bus.max_sw_i) : min_q;
    max_d     = load_edge ? (bus.min_sw_i < bus.max_sw_i ? bus.max_sw_i : bus.min_sw_i) : max_q;
    val_d     = normal && val_q < min_q              ? min_q :
                normal && val_q > max_q              ? max_q :
                bus.com_i[1] || (inc_step && dec_step) ? val_q :
                inc_step && val_q < hi               ? val_q + 1'b1 :
                dec_step && val_q > lo               ? val_q - 1'b1 : val_q;
    div_d     = div_q == DIV_LAST ? '0 : div_q + 1'b1;
    osc_d     = osc_q ^ (div_q == DIV_LAST);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      com_q  <= COM_NORMAL;
      min_q  <= '0;
      max_q  <= RST_MAX;
      val_q  <= '0;
      div_q  <= '0;
      osc_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      com_q  <= com_d;
      min_q  <= min_d;
      max_q  <= max_d;
      val_q  <= val_d;
      div_q  <= div_d;
      osc_q  <= osc_d;
      load_q <= bus.load_i;
    end
  assign bus.com_o = com_q;
  assign bus.min_o = min_q;
  assign bus.max_o = max_q;
  assign bus.val_o = val_q;
  assign bus.osc_o = osc_q;
endmodule

// File: tb/tb_min_max_ctrl.sv
// tb_min_max_ctrl: directed stimulus for min_max_ctrl, checked every cycle
// against a behavioural model plus hand-computed literal expectations.
module tb_min_max_ctrl;
  import min_max_pkg::*;
  localparam int VS = 4, OH = 4, RD = 6, RR = 2;
`ifdef MIN_MAX_CTRL_REPEAT_EN
  localparam bit REP = 1'b1;
  int exp6 [14] = '{1, 1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
`else
  localparam bit REP = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int checks = 0, failures = 0;
  int m_com, m_min, m_max, m_val, m_osc, m_cyc, m_inc_n, m_dec_n;
  bit m_load_p;

  min_max_ctrl_if #(.VALSIZE(VS)) bus ();
  min_max_ctrl #(.VALSIZE(VS), .OSC_HALF(OH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
  );
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_com = 0; m_min = 0; m_max = (1 << VS) - 1; m_val = 0; m_osc = 0;
    m_cyc = 0; m_inc_n = -1; m_dec_n = -1; m_load_p = 1'b0;
  endtask

  // n = cycles the button has been held, 0 on the cycle its rise is sampled
  function automatic bit stepping(input int n);
    return n == 0 || (REP && n >= RD && (n - RD) % RR == 0);
  endfunction

  always @(posedge rst_i) model_reset();

  always @(posedge clk_i) begin
    if (rst_i) model_reset();
    else begin
      int ni, nd, c, lo, hi, nv, a, b;
      bit inc_s, dec_s;
      ni = bus.inc_i ? (m_inc_n < 0 ? 0 : m_inc_n + 1) : -1;
      nd = bus.dec_i ? (m_dec_n < 0 ? 0 : m_dec_n + 1) : -1;
      inc_s = stepping(ni);
      dec_s = stepping(nd);
      c = int'(bus.com_i);
      if (c == 0 && (m_val < m_min || m_val > m_max)) nv = m_val < m_min ? m_min : m_max;
      else if (c >= 2 || (inc_s && dec_s)) nv = m_val;
      else begin
        lo = c == 0 ? m_min : 0;
        hi = c == 0 ? m_max : (1 << VS) - 1;
        nv = inc_s ? (m_val + 1 > hi ? hi : m_val + 1) :
             dec_s ? (m_val - 1 < lo ? lo : m_val - 1) : m_val;
      end
      if (bus.load_i && !m_load_p) begin
        a = int'(bus.min_sw_i);
        b = int'(bus.max_sw_i);
        m_min = a < b ? a : b;
        m_max = a < b ? b : a;
      end
      m_val = nv;
      m_load_p = bus.load_i;
      m_com = c;
      m_inc_n = ni;
      m_dec_n = nd;
      m_cyc++;
      m_osc = (m_cyc / OH) % 2;
    end
    #1;
    check("model_com", int'(bus.com_o), m_com);
    check("model_min", int'(bus.min_o), m_min);
    check("model_max", int'(bus.max_o), m_max);
    check("model_val", int'(bus.val_o), m_val);
    check("model_osc", int'(bus.osc_o), m_osc);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic press(input bit i, input bit d);
    bus.inc_i = i;
    bus.dec_i = d;
    tick(1);
    bus.inc_i = 1'b0;
    bus.dec_i = 1'b0;
    tick(1);
  endtask

  task automatic presses(input int n, input bit i, input bit d);
    repeat (n) press(i, d);
  endtask

  task automatic load(input int a, input int b);
    bus.min_sw_i = VS'(a);
    bus.max_sw_i = VS'(b);
    bus.load_i = 1'b1;
    tick(1);
    bus.load_i = 1'b0;
    tick(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_com"}, int'(bus.com_o), 0);
    check({tag, "_min"}, int'(bus.min_o), 0);
    check({tag, "_max"}, int'(bus.max_o), 15);
    check({tag, "_val"}, int'(bus.val_o), 0);
    check({tag, "_osc"}, int'(bus.osc_o), 0);
  endtask

  initial begin
    bus.com_i = COM_NORMAL;
    bus.min_sw_i = '0;
    bus.max_sw_i = '0;
    bus.load_i = 1'b0;
    bus.inc_i = 1'b0;
    bus.dec_i = 1'b0;
    tick(2);
    check_reset_vals("rst");
    rst_i = 1'b0;
    tick(3);
    check("osc_pre", int'(bus.osc_o), 0);
    tick(1);
    check("osc_rise", int'(bus.osc_o), 1);
    tick(3);
    check("osc_hold", int'(bus.osc_o), 1);
    tick(1);
    check("osc_fall", int'(bus.osc_o), 0);
    // swapped switches, then clamp on the following cycle
    bus.min_sw_i = 4'd12;
    bus.max_sw_i = 4'd3;
    bus.load_i = 1'b1;
    tick(1);
    check("load_min", int'(bus.min_o), 3);
    check("load_max", int'(bus.max_o), 12);
    check("load_val_same_cycle", int'(bus.val_o), 0);
    bus.load_i = 1'b0;
    tick(1);
    check("clamp_lo", int'(bus.val_o), 3);
    presses(12, 1'b1, 1'b0);
    check("norm_sat_hi", int'(bus.val_o), 12);
    bus.com_i = COM_LINEAR;
    tick(1);
    check("com_lin", int'(bus.com_o), 1);
    presses(3, 1'b1, 1'b0);
    check("lin_to_15", int'(bus.val_o), 15);
    press(1'b1, 1'b0);
    check("lin_sat_hi", int'(bus.val_o), 15);
    presses(16, 1'b0, 1'b1);
    check("lin_sat_lo", int'(bus.val_o), 0);
    presses(5, 1'b1, 1'b0);
    check("lin_to_5", int'(bus.val_o), 5);
    press(1'b1, 1'b1);
    check("both_hold", int'(bus.val_o), 5);
    bus.com_i = COM_ALL_OFF;
    bus.inc_i = 1'b1;
    tick(1);
    check("com_off", int'(bus.com_o), 2);
    check("off_hold", int'(bus.val_o), 5);
    bus.inc_i = 1'b0;
    tick(1);
    bus.com_i = COM_LINEAR;
    presses(9, 1'b1, 1'b0);
    check("lin_to_14", int'(bus.val_o), 14);
    bus.com_i = COM_NORMAL;
    tick(1);
    check("clamp_hi", int'(bus.val_o), 12);
    load(7, 7);
    check("eq_min", int'(bus.min_o), 7);
    check("eq_max", int'(bus.max_o), 7);
    check("eq_clamp", int'(bus.val_o), 7);
    press(1'b1, 1'b0);
    check("eq_inc", int'(bus.val_o), 7);
    press(1'b0, 1'b1);
    check("eq_dec", int'(bus.val_o), 7);
    load(3, 12);
    press(1'b1, 1'b0);
    check("pre_rst_val", int'(bus.val_o), 8);
    #1 rst_i = 1'b1;
    #1 check_reset_vals("async_rst");
    #2 rst_i = 1'b0;
    tick(1);
`ifdef MIN_MAX_CTRL_REPEAT_EN
    bus.com_i = COM_LINEAR;
    tick(1);
    bus.inc_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      check($sformatf("rep_%0d", i), int'(bus.val_o), exp6[i]);
    end
    bus.inc_i = 1'b0;
    tick(4);
    check("rep_release", int'(bus.val_o), 5);
`endif
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
